contadores_arriba_abajo: RTL and testbench

Set-mode up/down counter bank for the real-time clock.
- Holds three editable register groups: time-set (s/m/h), countdown-timer preset (s/m/h) and date (day/month/year).
- Push-button pulses step the field chosen by the cursor (counterlr) in the active group.
- Outputs feed the RTC write path and the display formatter.

---
 rtl/contadores_arriba_abajo.sv | 122 ++++++++++++
 tb/tb_contadores_arriba_abajo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/contadores_arriba_abajo.sv
// Set-mode up/down counter bank for the RTC: time-set, timer preset and date
// register groups, stepped one field at a time by debounced push-button edges.
module contadores_arriba_abajo (
    input  logic       clk,
    input  logic       swreset,
    input  logic       push_up,
    input  logic       push_down,
    input  logic       stime,
    input  logic       date,
    input  logic       timer,
    input  logic [4:0] counterlr,
    input  logic       sw,
    input  logic       swformat,
    output logic [5:0] counter_stime_s,
    output logic [5:0] counter_stime_m,
    output logic [4:0] counter_stime_h,
    output logic [5:0] counter_timer_s,
    output logic [5:0] counter_timer_m,
    output logic [4:0] counter_timer_h,
    output logic [4:0] counter_date_d,
    output logic [3:0] counter_date_m,
    output logic [6:0] counter_date_a
);

    localparam int unsigned SEL_W = 5;

    localparam logic [SEL_W-1:0] SEL_LOW  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MID  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_HIGH = SEL_W'(3);

    logic       up_q;
    logic       down_q;
    logic       up_ev;
    logic       down_ev;
    logic       step_up;
    logic       step_any;
    logic [4:0] max_day;
    logic       day_over;

    // Wrapping single step within [lo, hi]; all field widths fit in 7 bits.
    function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] lo,
                                             input logic [6:0] hi, input logic up);
        if (up) begin
            return (v >= hi) ? lo : v + 7'd1;
        end
        return (v <= lo) ? hi : v - 7'd1;
    endfunction

    assign up_ev    = push_up & ~up_q;
    assign down_ev  = push_down & ~down_q;
    assign step_up  = up_ev & ~down_ev;
    assign step_any = sw & (up_ev ^ down_ev);

    // Days in the current month; leap years are those with year[1:0] == 0.
    always_comb begin
        max_day = 5'd31;
        case (counter_date_m)
            4'd4, 4'd6, 4'd9, 4'd11: max_day = 5'd30;
            4'd2:                    max_day = (counter_date_a[1:0] == 2'd0) ? 5'd29 : 5'd28;
            default:                 max_day = 5'd31;
        endcase
    end

    assign day_over = (counter_date_d > max_day);

    always_ff @(posedge clk) begin
        if (!swreset) begin
            up_q            <= 1'b0;
            down_q          <= 1'b0;
            counter_stime_s <= 6'd0;
            counter_stime_m <= 6'd0;
            counter_stime_h <= swformat ? 5'd12 : 5'd0;
            counter_timer_s <= 6'd0;
            counter_timer_m <= 6'd0;
            counter_timer_h <= 5'd0;
            counter_date_d  <= 5'd1;
            counter_date_m  <= 4'd1;
            counter_date_a  <= 7'd0;
        end else begin
            up_q   <= push_up;
            down_q <= push_down;
            if (step_any) begin
                if (stime) begin
                    case (counterlr)
                        SEL_LOW:  counter_stime_s <= 6'(wrap_step(7'(counter_stime_s), 7'd0, 7'd59, step_up));
                        SEL_MID:  counter_stime_m <= 6'(wrap_step(7'(counter_stime_m), 7'd0, 7'd59, step_up));
                        SEL_HIGH: begin
                            if (!swformat) begin
                                counter_stime_h <= 5'(wrap_step(7'(counter_stime_h), 7'd0, 7'd23, step_up));
                            end else if (counter_stime_h == 5'd0 || counter_stime_h > 5'd12) begin
                                // Out-of-range value left over from 24-hour mode.
                                counter_stime_h <= step_up ? 5'd1 : 5'd12;
                            end else begin
                                counter_stime_h <= 5'(wrap_step(7'(counter_stime_h), 7'd1, 7'd12, step_up));
                            end
                        end
                        default: ;
                    endcase
                end else if (date) begin
                    case (counterlr)
                        SEL_LOW:  counter_date_d <= 5'(wrap_step(7'(counter_date_d), 7'd1, 7'(max_day), step_up));
                        SEL_MID:  counter_date_m <= 4'(wrap_step(7'(counter_date_m), 7'd1, 7'd12, step_up));
                        SEL_HIGH: counter_date_a <= wrap_step(counter_date_a, 7'd0, 7'd99, step_up);
                        default: ;
                    endcase
                end else if (timer) begin
                    case (counterlr)
                        SEL_LOW:  counter_timer_s <= 6'(wrap_step(7'(counter_timer_s), 7'd0, 7'd59, step_up));
                        SEL_MID:  counter_timer_m <= 6'(wrap_step(7'(counter_timer_m), 7'd0, 7'd59, step_up));
                        SEL_HIGH: counter_timer_h <= 5'(wrap_step(7'(counter_timer_h), 7'd0, 7'd23, step_up));
                        default: ;
                    endcase
                end
            end
            // Clamp after a month/year change; overrides any day step this edge.
            if (day_over) begin
                counter_date_d <= max_day;
            end
        end
    end

endmodule

// File: tb/tb_contadores_arriba_abajo.sv
// Bench for contadores_arriba_abajo: directed vector table, date corner sequences,
// then randomized stimulus against an arithmetic reference model.
module tb_contadores_arriba_abajo;

    logic       clk;
    logic       swreset;
    logic       push_up;
    logic       push_down;
    logic       stime;
    logic       date;
    logic       timer;
    logic [4:0] counterlr;
    logic       sw;
    logic       swformat;
    logic [5:0] counter_stime_s;
    logic [5:0] counter_stime_m;
    logic [4:0] counter_stime_h;
    logic [5:0] counter_timer_s;
    logic [5:0] counter_timer_m;
    logic [4:0] counter_timer_h;
    logic [4:0] counter_date_d;
    logic [3:0] counter_date_m;
    logic [6:0] counter_date_a;

    int checks = 0;
    int errors = 0;

    contadores_arriba_abajo dut (
        .clk             (clk),
        .swreset         (swreset),
        .push_up         (push_up),
        .push_down       (push_down),
        .stime           (stime),
        .date            (date),
        .timer           (timer),
        .counterlr       (counterlr),
        .sw              (sw),
        .swformat        (swformat),
        .counter_stime_s (counter_stime_s),
        .counter_stime_m (counter_stime_m),
        .counter_stime_h (counter_stime_h),
        .counter_timer_s (counter_timer_s),
        .counter_timer_m (counter_timer_m),
        .counter_timer_h (counter_timer_h),
        .counter_date_d  (counter_date_d),
        .counter_date_m  (counter_date_m),
        .counter_date_a  (counter_date_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Field ids: 0 ss, 1 sm, 2 sh, 3 ts, 4 tm, 5 th, 6 day, 7 month, 8 year.
    localparam int F_SS = 0, F_SM = 1, F_SH = 2, F_TS = 3, F_TM = 4, F_TH = 5;
    localparam int F_DD = 6, F_DM = 7, F_DA = 8;

    function automatic int get_out(input int f);
        case (f)
            F_SS:    return int'(counter_stime_s);
            F_SM:    return int'(counter_stime_m);
            F_SH:    return int'(counter_stime_h);
            F_TS:    return int'(counter_timer_s);
            F_TM:    return int'(counter_timer_m);
            F_TH:    return int'(counter_timer_h);
            F_DD:    return int'(counter_date_d);
            F_DM:    return int'(counter_date_m);
            default: return int'(counter_date_a);
        endcase
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_f[9];
    bit m_upq, m_dnq;
    bit mu, md_ev, su, sd, clamp;
    int dir, mdays, sel;

    function automatic int days_in(input int mon, input int yr);
        int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mon == 2 && (yr % 4) == 0) return 29;
        return tbl[mon - 1];
    endfunction

    function automatic int wrap(input int v, input int d, input int lo, input int n);
        return lo + ((v - lo + d + n) % n);
    endfunction

    always @(posedge clk) begin
        if (!swreset) begin
            foreach (m_f[i]) m_f[i] = 0;
            m_f[F_SH] = swformat ? 12 : 0;
            m_f[F_DD] = 1;
            m_f[F_DM] = 1;
            m_upq = 0;
            m_dnq = 0;
        end else begin
            mu    = push_up && !m_upq;
            md_ev = push_down && !m_dnq;
            su    = sw && mu && !md_ev;
            sd    = sw && md_ev && !mu;
            dir   = su ? 1 : -1;
            mdays = days_in(m_f[F_DM], m_f[F_DA]);
            clamp = m_f[F_DD] > mdays;
            sel   = int'(counterlr);
            if ((su || sd) && sel >= 1 && sel <= 3) begin
                if (stime) begin
                    if (sel == 1) m_f[F_SS] = wrap(m_f[F_SS], dir, 0, 60);
                    else if (sel == 2) m_f[F_SM] = wrap(m_f[F_SM], dir, 0, 60);
                    else if (!swformat) m_f[F_SH] = wrap(m_f[F_SH], dir, 0, 24);
                    else if (m_f[F_SH] < 1 || m_f[F_SH] > 12) m_f[F_SH] = su ? 1 : 12;
                    else m_f[F_SH] = wrap(m_f[F_SH], dir, 1, 12);
                end else if (date) begin
                    if (sel == 1 && !clamp) m_f[F_DD] = wrap(m_f[F_DD], dir, 1, mdays);
                    else if (sel == 2) m_f[F_DM] = wrap(m_f[F_DM], dir, 1, 12);
                    else if (sel == 3) m_f[F_DA] = wrap(m_f[F_DA], dir, 0, 100);
                end else if (timer) begin
                    if (sel == 1) m_f[F_TS] = wrap(m_f[F_TS], dir, 0, 60);
                    else if (sel == 2) m_f[F_TM] = wrap(m_f[F_TM], dir, 0, 60);
                    else m_f[F_TH] = wrap(m_f[F_TH], dir, 0, 24);
                end
            end
            if (clamp) m_f[F_DD] = mdays;
            m_upq = push_up;
            m_dnq = push_down;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       sw;
        logic       st;
        logic       dt;
        logic       tm;
        logic       fmt;
        logic       up;
        logic       dn;
        logic [4:0] lr;
        int         fld;
        int         exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic swv, input logic st, input logic dt,
                                input logic tm, input logic fmt, input logic up, input logic dn,
                                input int lr, input int fld, input int exp);
        vec_t r;
        r.rst = rst; r.sw = swv; r.st = st; r.dt = dt; r.tm = tm; r.fmt = fmt;
        r.up = up; r.dn = dn; r.lr = 5'(lr); r.fld = fld; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        swreset = r.rst; sw = r.sw; stime = r.st; date = r.dt; timer = r.tm;
        swformat = r.fmt; push_up = r.up; push_down = r.dn; counterlr = r.lr;
    endtask

    task automatic press(input int lr, input bit up);
        counterlr = 5'(lr);
        push_up   = up;
        push_down = !up;
        @(negedge clk);
        push_up   = 1'b0;
        push_down = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        swreset = 1'b0; push_up = 1'b0; push_down = 1'b0; stime = 1'b0; date = 1'b0;
        timer = 1'b0; counterlr = 5'd0; sw = 1'b0; swformat = 1'b1;

        //                rst sw st dt tm fmt up dn lr  field exp
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, F_SH, 12));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, F_DD, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, F_DM, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, F_TH, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_SH, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 3, F_SH, 23));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 3, F_SH, 23));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 3, F_SH, 23));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 3, F_SH, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 1, 3, F_SH, 12));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 12));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 5, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 3, F_SH, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0, 1, F_SS, 1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 1, F_TS, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 1, F_TS, 59));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, F_TS, 59));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 1, F_TS, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, F_TM, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 1, F_SS, 1));

        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_f%0d", i, tbl[i].fld), get_out(tbl[i].fld), tbl[i].exp);
        end

        // Date group corners: Feb wrap in common/leap years and the month-change clamp.
        stime = 1'b0; timer = 1'b0; date = 1'b1; sw = 1'b1;
        press(3, 1'b1); chk("year_up", get_out(F_DA), 1);
        press(2, 1'b1); chk("month_up", get_out(F_DM), 2);
        press(1, 1'b0); chk("feb_common_down_wrap", get_out(F_DD), 28);
        press(1, 1'b1); chk("feb_common_up_wrap", get_out(F_DD), 1);
        for (int i = 0; i < 3; i++) press(3, 1'b1);
        chk("year_four", get_out(F_DA), 4);
        press(1, 1'b0); chk("feb_leap_down_wrap", get_out(F_DD), 29);
        press(1, 1'b0); press(1, 1'b1); chk("feb_leap_up_28_29", get_out(F_DD), 29);
        press(2, 1'b1); press(1, 1'b1); press(1, 1'b1);
        chk("march_day31", get_out(F_DD), 31);
        counterlr = 5'd2; push_up = 1'b1;
        @(negedge clk);
        chk("april_month", get_out(F_DM), 4);
        chk("clamp_not_yet", get_out(F_DD), 31);
        push_up = 1'b0;
        @(negedge clk);
        chk("clamp_april", get_out(F_DD), 30);
        press(2, 1'b1); press(1, 1'b1);
        chk("may_day31", get_out(F_DD), 31);
        counterlr = 5'd2; push_down = 1'b1;
        @(negedge clk);
        chk("may_to_april", get_out(F_DM), 4);
        push_down = 1'b0; counterlr = 5'd1; push_up = 1'b1;
        @(negedge clk);
        chk("clamp_beats_step", get_out(F_DD), 30);
        push_up = 1'b0;
        @(negedge clk);

        // Randomized phase against the reference model.
        for (int n = 0; n < 3000; n++) begin
            swreset   = ($urandom_range(0, 63) != 0);
            push_up   = 1'($urandom_range(0, 1));
            push_down = 1'($urandom_range(0, 3) == 0);
            stime     = 1'($urandom_range(0, 2) == 0);
            date      = 1'($urandom_range(0, 1));
            timer     = 1'($urandom_range(0, 1));
            counterlr = 5'($urandom_range(0, 5));
            sw        = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) swformat = ~swformat;
            @(negedge clk);
            for (int f = 0; f < 9; f++) chk($sformatf("rand%0d_f%0d", n, f), get_out(f), m_f[f]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
